// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: push-button byte sender and NIC receive reader.
// A synchronised button press queues send_data_i for transmission. A
// round-robin FSM (IDLE/RD/WR/GAP) then interleaves NIC reads and writes,
// keeping at least three cycles between any two strobes.
// Build option: define UART_HOST_TXQ_EN to replace the single pending byte
// with a FIFO_DEPTH-entry TX FIFO. The default build uses one pending register.
module uart_host_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_button,
    input  logic [7:0] send_data_i,
    input  logic       nic_tx_ready,
    input  logic       nic_rx_valid,
    input  logic [7:0] rec_data_from_nic,
    output logic [7:0] send_data_to_nic,
    output logic       write_nic,
    output logic       read_nic,
    output logic [7:0] data_display,
    output logic [3:0] num_data_received,
    output logic       tx_drop,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        GAP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_RX = 1'b0,
        GNT_TX = 1'b1
    } grant_t;

    state_t     state;
    state_t     state_nxt;
    grant_t     last_grant;

    // Button synchroniser and press detection.
    logic       btn_s1;
    logic       btn_s2;
    logic       btn_prev;
    logic [1:0] warm;
    logic       armed;
    logic       press;

    // Interface between the TX store and the FSM.
    logic       push;
    logic       pop;
    logic       full;
    logic       tx_pend;
    logic [7:0] tx_head;

    // Arbitration.
    logic       run_ok;
    logic       rx_req;
    logic       tx_req;

    // Two-flop synchroniser plus an edge register. warm counts the edges
    // until btn_s2 carries a real sample. armed is set once a genuine low has
    // been seen, so a button held through reset release yields no event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_prev <= 1'b0;
            warm     <= 2'd0;
            armed    <= 1'b0;
        end else begin
            btn_s1   <= send_button;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            if (warm != 2'd2)
                warm <= warm + 2'd1;
            if (warm == 2'd2 && !btn_s2)
                armed <= 1'b1;
        end
    end

    assign press = armed & btn_s2 & ~btn_prev;

    // The WR cycle pops the head. That frees a full slot for a press that
    // arrives in the same cycle, so the press is accepted.
    assign pop  = (state == WR);
    assign push = press & (~full | pop);

`ifdef UART_HOST_TXQ_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    q_mem [FIFO_DEPTH];
    logic [AW-1:0] q_wr;
    logic [AW-1:0] q_rd;
    logic [CW-1:0] q_cnt;

    // FIFO storage. The storage needs no reset because q_cnt gates its use.
    always_ff @(posedge clk) begin
        if (push)
            q_mem[q_wr] <= send_data_i;
    end

    // FIFO pointers and occupancy. Pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (push)
                q_wr <= q_wr + AW'(1);
            if (pop)
                q_rd <= q_rd + AW'(1);
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + CW'(1);
                2'b01:   q_cnt <= q_cnt - CW'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    assign full    = (q_cnt == CW'(FIFO_DEPTH));
    assign tx_pend = (q_cnt != '0);
    assign tx_head = q_mem[q_rd];
`else
    logic       pend_valid;
    logic [7:0] pend_byte;
    logic       cfg_unused;

    // FIFO_DEPTH has no effect on the single-entry build.
    assign cfg_unused = (FIFO_DEPTH != 0);

    // Single pending byte. A push in the pop cycle refills the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_byte  <= 8'h00;
        end else if (push) begin
            pend_valid <= 1'b1;
            pend_byte  <= send_data_i;
        end else if (pop) begin
            pend_valid <= 1'b0;
        end
    end

    assign full    = pend_valid;
    assign tx_pend = pend_valid;
    assign tx_head = pend_byte;
`endif

    // Requests are masked for the first cycle after reset release, so no
    // strobe can follow reset deassertion immediately.
    assign rx_req = nic_rx_valid & run_ok;
    assign tx_req = tx_pend & nic_tx_ready & run_ok;

    // Next-state logic. When both sides request, round-robin gives the grant
    // to the side that did not win last time.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_req && tx_req)
                    state_nxt = (last_grant == GNT_TX) ? RD : WR;
                else if (rx_req)
                    state_nxt = RD;
                else if (tx_req)
                    state_nxt = WR;
            end
            RD:      state_nxt = GAP;
            WR:      state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered strobes. The strobes are decoded from
    // the next state, so each pulse covers exactly the RD or WR cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= GNT_TX;
            run_ok           <= 1'b0;
            read_nic         <= 1'b0;
            write_nic        <= 1'b0;
            send_data_to_nic <= 8'h00;
        end else begin
            state     <= state_nxt;
            run_ok    <= 1'b1;
            read_nic  <= (state_nxt == RD);
            write_nic <= (state_nxt == WR);
            if (state_nxt == WR) begin
                send_data_to_nic <= tx_head;
                last_grant       <= GNT_TX;
            end else if (state_nxt == RD) begin
                last_grant       <= GNT_RX;
            end
        end
    end

    // Capture the received byte and bump the 4-bit receive count in the RD
    // cycle. The count wraps from 15 to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_display      <= 8'h00;
            num_data_received <= 4'd0;
        end else if (state == RD) begin
            data_display      <= rec_data_from_nic;
            num_data_received <= num_data_received + 4'd1;
        end
    end

    // Sticky drop flag. Only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_drop <= 1'b0;
        else if (press && full && !pop)
            tx_drop <= 1'b1;
    end

    assign busy = (state != IDLE) | tx_pend;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb_uart_host_ctrl: directed and randomized checks of uart_host_ctrl against
// a queue-based NIC model and expected values derived from the block's rules.
`timescale 1ns/1ps
module tb_uart_host_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_button = 1'b0;
    logic [7:0] send_data_i = 8'h00;
    logic       nic_tx_ready = 1'b0;
    logic       nic_rx_valid = 1'b0;
    logic [7:0] rec_data_from_nic = 8'h00;
    logic [7:0] send_data_to_nic;
    logic       write_nic;
    logic       read_nic;
    logic [7:0] data_display;
    logic [3:0] num_data_received;
    logic       tx_drop;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_host_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .send_button       (send_button),
        .send_data_i       (send_data_i),
        .nic_tx_ready      (nic_tx_ready),
        .nic_rx_valid      (nic_rx_valid),
        .rec_data_from_nic (rec_data_from_nic),
        .send_data_to_nic  (send_data_to_nic),
        .write_nic         (write_nic),
        .read_nic          (read_nic),
        .data_display      (data_display),
        .num_data_received (num_data_received),
        .tx_drop           (tx_drop),
        .busy              (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // NIC model: receive FIFO of bytes, popped in the cycle after read_nic.
    logic [7:0] rxq[$];
    logic       tx_en = 1'b0;
    logic       rd_seen = 1'b0;
    logic [7:0] exp_disp = 8'h00;
    int         exp_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            rd_seen  = 1'b0;
            exp_disp = 8'h00;
            exp_cnt  = 0;
        end else begin
            if (rd_seen && rxq.size() != 0) begin
                exp_disp = rxq.pop_front();
                exp_cnt++;
            end
            rd_seen = read_nic;
        end
        nic_rx_valid      = (rxq.size() != 0);
        rec_data_from_nic = (rxq.size() != 0) ? rxq[0] : 8'h00;
        nic_tx_ready      = tx_en;
    end

    // Strobe monitor: strobes must be exclusive and at least 3 cycles apart.
    // It also logs the strobe order and the transmitted bytes.
    int         cyc = 0;
    int         last_stb = -100;
    logic [7:0] kinds[$];
    int         strobe_cyc[$];
    logic [7:0] txlog[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            last_stb = -100;
        end else if (read_nic || write_nic) begin
            chk("one_strobe", {31'd0, read_nic & write_nic}, 32'd0);
            chk("spacing", {31'd0, (cyc - last_stb) >= 3}, 32'd1);
            last_stb = cyc;
            kinds.push_back(read_nic ? 8'h52 : 8'h57);
            strobe_cyc.push_back(cyc);
            if (write_nic)
                txlog.push_back(send_data_to_nic);
        end
    end

    function automatic logic [7:0] kind_at(input int i);
        if (i < kinds.size())
            return kinds[i];
        return 8'h00;
    endfunction

    function automatic logic [7:0] tx_at(input int i);
        if (i < txlog.size())
            return txlog[i];
        return 8'hxx;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input logic [7:0] b, input int hold = 4, input int low = 4);
        send_data_i = b;
        send_button = 1'b1;
        tick(hold);
        send_button = 1'b0;
        tick(low);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        send_button = 1'b0;
        tx_en       = 1'b0;
        rxq.delete();
        txlog.delete();
        kinds.delete();
        strobe_cyc.delete();
        tick(3);
        rst = 1'b0;
        tick(4);
    endtask

    task automatic wait_drain(input string tag, input int max = 300);
        int k;
        k = 0;
        while (k < max && !(rxq.size() == 0 && !busy && !nic_rx_valid && !rd_seen)) begin
            tick();
            k++;
        end
        chk({tag, "_drain"}, {31'd0, k < max}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] last_rx;
        logic [7:0] pressed[$];
        logic       ok;
        int         j;
        int         k;

        // Reset state.
        tick(2);
        chk("rst_write", {31'd0, write_nic}, 32'd0);
        chk("rst_read", {31'd0, read_nic}, 32'd0);
        chk("rst_sdata", {24'd0, send_data_to_nic}, 32'd0);
        chk("rst_disp", {24'd0, data_display}, 32'd0);
        chk("rst_cnt", {28'd0, num_data_received}, 32'd0);
        chk("rst_drop", {31'd0, tx_drop}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick(4);

        // A press of 0xA5 gives write_nic exactly on the 4th edge after the pin edge.
        tx_en = 1'b1;
        tick(3);
        txlog.delete();
        send_data_i = 8'hA5;
        send_button = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat_wr_e%0d", i), {31'd0, write_nic}, {31'd0, i == 4});
        end
        chk("lat_data", {24'd0, send_data_to_nic}, 32'h0000_00A5);
        @(posedge clk);
        #1;
        chk("wr_one_cycle", {31'd0, write_nic}, 32'd0);
        send_button = 1'b0;
        tick(6);
        chk("a5_writes", txlog.size(), 32'd1);
        chk("hold_sdata", {24'd0, send_data_to_nic}, 32'h0000_00A5);

        // Two reads, 0x3C then 0x7E, spaced three cycles apart.
        kinds.delete();
        strobe_cyc.delete();
        rxq.push_back(8'h3C);
        rxq.push_back(8'h7E);
        wait_drain("rx2");
        chk("rx2_n", kinds.size(), 32'd2);
        chk("rx2_gap", (strobe_cyc.size() == 2) ? strobe_cyc[1] - strobe_cyc[0] : -1, 32'd3);
        chk("rx2_disp", {24'd0, data_display}, 32'h0000_007E);
        chk("rx2_cnt", {28'd0, num_data_received}, 32'd2);

        // Both sides requesting: RX wins first, then TX, then RX.
        do_reset();
        press(8'hB1);
        chk("rr_pend_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            rxq.push_back(b);
        end
        tx_en = 1'b1;
        wait_drain("rr");
        chk("rr_k0", {24'd0, kind_at(0)}, 32'h52);
        chk("rr_k1", {24'd0, kind_at(1)}, 32'h57);
        chk("rr_k2", {24'd0, kind_at(2)}, 32'h52);
        chk("rr_tx", {24'd0, tx_at(0)}, 32'h0000_00B1);
        chk("rr_cnt", {28'd0, num_data_received}, 32'd4);
        chk("rr_disp", {24'd0, data_display}, {24'd0, exp_disp});

        // A press landing in the WR pop cycle is accepted, not dropped.
        do_reset();
        press(8'h5A);
        send_data_i = 8'hC3;
        send_button = 1'b1;
        tick();
        tx_en = 1'b1;
        tick(4);
        send_button = 1'b0;
        tick(4);
        wait_drain("coinc");
        chk("coinc_n", txlog.size(), 32'd2);
        chk("coinc_b0", {24'd0, tx_at(0)}, 32'h0000_005A);
        chk("coinc_b1", {24'd0, tx_at(1)}, 32'h0000_00C3);
        chk("coinc_drop", {31'd0, tx_drop}, 32'd0);

        // Two presses while the NIC is not ready.
        do_reset();
        press(8'h11);
        press(8'h22);
`ifdef UART_HOST_TXQ_EN
        chk("q_drop", {31'd0, tx_drop}, 32'd0);
`else
        chk("q_drop", {31'd0, tx_drop}, 32'd1);
`endif
        tx_en = 1'b1;
        wait_drain("q");
        chk("q_b0", {24'd0, tx_at(0)}, 32'h0000_0011);
`ifdef UART_HOST_TXQ_EN
        chk("q_n", txlog.size(), 32'd2);
        chk("q_b1", {24'd0, tx_at(1)}, 32'h0000_0022);
        chk("q_drop_after", {31'd0, tx_drop}, 32'd0);
`else
        chk("q_n", txlog.size(), 32'd1);
        chk("q_drop_sticky", {31'd0, tx_drop}, 32'd1);
`endif

        // Seventeen reads from reset: the count wraps to 1.
        do_reset();
        last_rx = 8'h00;
        for (int i = 0; i < 17; i++) begin
            last_rx = 8'($urandom);
            rxq.push_back(last_rx);
        end
        wait_drain("r17", 400);
        chk("r17_cnt", {28'd0, num_data_received}, 32'd1);
        chk("r17_disp", {24'd0, data_display}, {24'd0, last_rx});
        chk("r17_model", {28'd0, num_data_received}, exp_cnt % 16);

        // A button held through reset release produces no press.
        rst = 1'b1;
        send_button = 1'b1;
        send_data_i = 8'hEE;
        tx_en = 1'b1;
        tick(3);
        txlog.delete();
        rst = 1'b0;
        tick(8);
        chk("held_busy", {31'd0, busy}, 32'd0);
        send_button = 1'b0;
        tick(4);
        chk("held_nowr", txlog.size(), 32'd0);
        press(8'h77);
        wait_drain("held");
        chk("held_next", {24'd0, tx_at(0)}, 32'h0000_0077);

        // Reset asserted in a WR cycle aborts it and leaves no early strobe after release.
        do_reset();
        press(8'h99);
        tx_en = 1'b1;
        k = 0;
        while (!write_nic && k < 20) begin
            tick();
            k++;
        end
        chk("r39_in_wr", {31'd0, write_nic}, 32'd1);
        rst = 1'b1;
        rxq.push_back(8'h4D);
        #1;
        chk("r39_wr_low", {31'd0, write_nic}, 32'd0);
        chk("r39_sdata", {24'd0, send_data_to_nic}, 32'd0);
        chk("r39_busy", {31'd0, busy}, 32'd0);
        chk("r39_cnt", {28'd0, num_data_received}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick();
        chk("r39_no_rd", {31'd0, read_nic}, 32'd0);
        chk("r39_no_wr", {31'd0, write_nic}, 32'd0);
        wait_drain("r39");
        chk("r39_disp", {24'd0, data_display}, 32'h0000_004D);
        chk("r39_aborted", txlog.size(), 32'd0);

        // Randomized traffic against the queue model.
        do_reset();
        pressed.delete();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                rxq.push_back(b);
            end
            tx_en = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            pressed.push_back(b);
            press(b, int'($urandom_range(3, 6)), int'($urandom_range(3, 8)));
        end
        tx_en = 1'b1;
        wait_drain("rand", 600);
        ok = 1'b1;
        j = 0;
        foreach (txlog[i]) begin
            while (j < pressed.size() && pressed[j] != txlog[i])
                j++;
            if (j >= pressed.size())
                ok = 1'b0;
            else
                j++;
        end
        chk("rand_order", {31'd0, ok}, 32'd1);
        chk("rand_drop", {31'd0, tx_drop}, {31'd0, txlog.size() != pressed.size()});
        chk("rand_cnt", {28'd0, num_data_received}, exp_cnt % 16);
        chk("rand_disp", {24'd0, data_display}, {24'd0, exp_disp});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_host_ctrl.md
UART_HOST_CTRL -- requirements
Module: uart_host_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, TX queue depth (power of 2, 2..16) when UART_HOST_TXQ_EN is defined.
REQ-002 SHALL have port clk  input  1  single system clock, all flops rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port send_button  input  1  raw, asynchronous push-button level, high = pressed.
REQ-005 SHALL have port send_data_i  input  8  byte to transmit, sampled on the detected press edge.
REQ-006 SHALL have port nic_tx_ready  input  1  NIC can accept one byte.
REQ-007 SHALL have port nic_rx_valid  input  1  NIC holds an unread received byte.
REQ-008 SHALL have port rec_data_from_nic  input  8  received byte, valid while nic_rx_valid.
REQ-009 SHALL have port send_data_to_nic  output  8  byte presented to the NIC, valid while write_nic.
REQ-010 SHALL have port write_nic  output  1  one-cycle write strobe.
REQ-011 SHALL have port read_nic  output  1  one-cycle read/pop strobe.
REQ-012 SHALL have port data_display  output  8  last byte read from the NIC.
REQ-013 SHALL have port num_data_received  output  4  count of bytes read, modulo 16.
REQ-014 SHALL have port tx_drop  output  1  sticky: a press was discarded.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not in IDLE or a TX byte is pending.

Function
REQ-016 SHALL synchronise send_button through two flops; a press event = synchronised 0->1 transition, exactly one event per press.
REQ-017 SHALL, on a press event with no TX byte pending, latch send_data_i into the pending register the same cycle.
REQ-018 SHALL, on a press event while a byte is pending (queue full), discard the new byte and set tx_drop.
REQ-019 SHALL implement FSM states IDLE, RD, WR, GAP; all registered outputs.
REQ-020 IDLE: rx_req = nic_rx_valid; tx_req = pending & nic_tx_ready; none -> stay IDLE.
REQ-021 IDLE arbitration SHALL be round-robin: single request granted; both requesting -> grant the opposite of last_grant (reset value: TX, so RX wins first).
REQ-022 RD: read_nic=1 for exactly one cycle; data_display <= rec_data_from_nic and num_data_received += 1 in that cycle; 15 wraps to 0; next state GAP.
REQ-023 WR: write_nic=1 for exactly one cycle with send_data_to_nic = pending byte; pending released (or queue popped) that cycle; next state GAP.
REQ-024 GAP: one idle cycle for NIC status to update, strobes low; next state IDLE.
REQ-025 Minimum spacing between any two strobes SHALL be 3 cycles; grant-to-strobe latency 1 cycle from the IDLE cycle.
REQ-026 A press event coinciding with a WR pop SHALL be accepted (pop frees the slot that cycle), not dropped.
REQ-027 send_data_to_nic SHALL hold its last value outside WR.
REQ-028 tx_drop SHALL clear only on reset.

Reset
REQ-029 rst SHALL asynchronously force: state IDLE, write_nic=0, read_nic=0, send_data_to_nic=0, data_display=0, num_data_received=0, tx_drop=0, pending/queue empty, sync flops 0, last_grant=TX.
REQ-030 Reset mid-RD or mid-WR SHALL abort; no strobe in the cycle following deassertion.
REQ-031 Button held high across reset release SHALL not generate a press event.

Configuration
REQ-032 Macro UART_HOST_TXQ_EN defined: pending register replaced by FIFO_DEPTH-entry FIFO; push on press, pop in WR, drop and set tx_drop only when full; bytes sent in press order.
REQ-033 Macro UART_HOST_TXQ_EN undefined: single-entry pending register, FIFO_DEPTH ignored.

Verification
REQ-034 Press with send_data_i=0xA5, nic_tx_ready=1 -> one write_nic pulse, send_data_to_nic=0xA5, 4 cycles after press edge at pin (2 sync + 1 IDLE + 1).
REQ-035 nic_rx_valid=1 with data 0x3C, 0x7E on successive reads -> two read_nic pulses 3 cycles apart, data_display ends 0x7E, num_data_received=2.
REQ-036 rx and tx pending continuously -> strobes alternate RD, WR, RD, WR, first is RD.
REQ-037 17 reads from reset -> num_data_received=1.
REQ-038 nic_tx_ready=0, presses 0x11 then 0x22 -> without macro 0x22 dropped, tx_drop=1; with macro both queued, sent 0x11 then 0x22 after nic_tx_ready=1, tx_drop=0.
REQ-039 rst asserted in WR cycle -> write_nic low immediately, all outputs at reset values, no strobe one cycle after release.
